nibble_serial_adder: RTL and testbench

Sequencer that adds or subtracts two NIBBLES×4-bit operands one nibble per cycle on the team's 4-bit ripple-carry adder stage. It sits directly upstream of that stage: it drives the adder's A/B/Cin, registers its S/Cout, and chains the carry between nibbles. Operands arrive and results leave over valid/ready handshakes, so a narrow adder can serve a wide datapath.

---
 rtl/nibble_serial_adder.sv | 136 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Sequences a W-bit add/subtract through an external 4-bit ripple-carry stage, one nibble per cycle.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to register signed overflow; otherwise overflow is tied to 0.
module nibble_serial_adder #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   input  logic                   op_sub,
   output logic [3:0]             add_a,
   output logic [3:0]             add_b,
   output logic                   add_cin,
   input  logic [3:0]             add_s,
   input  logic                   add_cout,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   carry_out,
   output logic                   overflow
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned IdxW = $clog2(NIBBLES);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic            carry_q, carry_d, cout_q, cout_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [3:0]      a_nib, b_nib;
   logic            last_step;

   always_comb begin
      a_nib = a_q[3:0];
      b_nib = b_q[3:0];
      for (int i = 0; i < int'(NIBBLES); i++) begin
         if (idx_q == IdxW'(i)) begin
            a_nib = a_q[i*4 +: 4];
            b_nib = b_q[i*4 +: 4];
         end
      end
   end

   assign last_step = (state_q == StRun) && (idx_q == LastIdx);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               // b is stored pre-inverted so RUN never needs to know the operation
               a_d     = op_a;
               b_d     = op_b ^ {W{op_sub}};
               carry_d = op_sub;
               idx_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            for (int i = 0; i < int'(NIBBLES); i++) begin
               if (idx_q == IdxW'(i)) sum_d[i*4 +: 4] = add_s;
            end
            carry_d = add_cout;
            idx_d   = idx_q + IdxW'(1);
            if (last_step) begin
               cout_d  = add_cout;
               idx_d   = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign add_a     = (state_q == StRun) ? a_nib : 4'h0;
   assign add_b     = (state_q == StRun) ? b_nib : 4'h0;
   assign add_cin   = (state_q == StRun) ? carry_q : 1'b0;
   assign sum       = sum_q;
   assign carry_out = cout_q;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic ovf_q, ovf_d;

   // add_s[3] is the result MSB during the final nibble
   always_comb begin
      ovf_d = ovf_q;
      if (last_step) ovf_d = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
   end

   always_ff @(posedge clk) begin
      if (reset) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end

   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit adder stage.
module tb_nibble_serial_adder;

   localparam int unsigned NIB = 4;
   localparam int unsigned W   = 4 * NIB;

   logic         clk = 1'b0;
   logic         reset, in_valid, in_ready, op_sub;
   logic [W-1:0] op_a, op_b, sum;
   logic [3:0]   add_a, add_b, add_s;
   logic         add_cin, add_cout;
   logic         out_valid, out_ready, carry_out, overflow;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   // The external ripple-carry stage, purely combinational
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

   nibble_serial_adder #(.NIBBLES(NIB)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sub    (op_sub),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_s     (add_s),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      exp_t       e;
      logic [W:0] full;
      if (sub) begin
         e.s = a - b;
         e.c = (a >= b);
      end else begin
         full = {1'b0, a} + {1'b0, b};
         e.s  = full[W-1:0];
         e.c  = full[W];
      end
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      if (sub) e.v = (a[W-1] != b[W-1]) && (e.s[W-1] != a[W-1]);
      else     e.v = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
`else
      e.v = 1'b0;
`endif
      return e;
   endfunction

   // Present one request for a single cycle; expectation is queued only if it can be taken.
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      int n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
      end
      op_a     = a;
      op_b     = b;
      op_sub   = sub;
      in_valid = 1'b1;
      if (in_ready) sb.push_back(model(a, b, sub));
      step();
      in_valid = 1'b0;
      op_a     = W'($urandom);
      op_b     = W'($urandom);
      op_sub   = 1'($urandom);
   endtask

   // Latency counted from the cycle in_valid was presented.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      op_a = '0;
      op_b = '0;
      op_sub = 1'b0;
      step();
      step();
      reset = 1'b0;
      total++;
      if ({in_ready, out_valid, sum, carry_out, overflow} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_outputs rdy=%b vld=%b sum=%h co=%b ov=%b required 1 0 0000 0 0",
                  in_ready, out_valid, sum, carry_out, overflow);
      end
      total++;
      if ({add_a, add_b, add_cin} !== 9'h0) begin
         bad++;
         $display("FAIL reset_adder_drive a=%h b=%h cin=%b required 0 0 0", add_a, add_b, add_cin);
      end
   endtask

   task automatic test_add();
      int   lat;
      exp_t e;
      accept(16'h1234, 16'h0FCD, 1'b0);
      wait_done(lat);
      total++;
      if (lat !== 5 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL add_latency lat=%0d vld=%b required 5 1", lat, out_valid);
      end
      total++;
      if (sum !== 16'h2201) begin
         bad++;
         $display("FAIL add_const sum=%h required 2201", sum);
      end
      e = sb.pop_front();
      total++;
      if ({sum, carry_out, overflow} !== {e.s, e.c, e.v}) begin
         bad++;
         $display("FAIL add_result got %h/%b/%b required %h/%b/%b",
                  sum, carry_out, overflow, e.s, e.c, e.v);
      end
      total++;
      if ({add_a, add_b, add_cin} !== 9'h0) begin
         bad++;
         $display("FAIL done_adder_drive a=%h b=%h cin=%b required 0 0 0", add_a, add_b, add_cin);
      end
      step();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL add_release rdy=%b vld=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_carry_chain();
      logic [3:0] cins;
      int         lat;
      exp_t       e;
      accept(16'hFFFF, 16'h0001, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cins[i] = add_cin;
         step();
      end
      wait_done(lat);
      total++;
      if (cins !== 4'b1110) begin
         bad++;
         $display("FAIL carry_cin_seq got %b required 1110 (first nibble in bit0)", cins);
      end
      e = sb.pop_front();
      total++;
      if ({sum, carry_out, overflow} !== {e.s, e.c, e.v} || {sum, carry_out} !== {16'h0, 1'b1}) begin
         bad++;
         $display("FAIL carry_result got %h/%b/%b required %h/%b/%b",
                  sum, carry_out, overflow, e.s, e.c, e.v);
      end
      step();
   endtask

   task automatic test_overflow();
      int   lat;
      exp_t e;
      logic exp_v;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      exp_v = 1'b1;
`else
      exp_v = 1'b0;
`endif
      accept(16'h7FFF, 16'h0001, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      total++;
      if ({sum, carry_out, overflow} !== {16'h8000, 1'b0, exp_v} || overflow !== e.v) begin
         bad++;
         $display("FAIL ovf_result got %h/%b/%b required 8000/0/%b", sum, carry_out, overflow, exp_v);
      end
      step();
   endtask

   task automatic test_sub();
      int   lat;
      exp_t e;
      accept(16'h0005, 16'h0007, 1'b1);
      wait_done(lat);
      e = sb.pop_front();
      total++;
      if ({sum, carry_out} !== {16'hFFFE, 1'b0} || {sum, carry_out, overflow} !== {e.s, e.c, e.v}) begin
         bad++;
         $display("FAIL sub_borrow got %h/%b/%b required fffe/0/%b", sum, carry_out, overflow, e.v);
      end
      step();
      accept(16'h0007, 16'h0005, 1'b1);
      wait_done(lat);
      e = sb.pop_front();
      total++;
      if ({sum, carry_out} !== {16'h0002, 1'b1} || {sum, carry_out, overflow} !== {e.s, e.c, e.v}) begin
         bad++;
         $display("FAIL sub_noborrow got %h/%b/%b required 0002/1/%b", sum, carry_out, overflow, e.v);
      end
      step();
   endtask

   task automatic test_backpressure();
      int           lat;
      exp_t         e;
      logic [W-1:0] held;
      int           errs = 0;
      out_ready = 1'b0;
      accept(16'hA5A5, 16'h1111, 1'b0);
      wait_done(lat);
      held = sum;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         op_a = 16'h0F0F;
         op_b = 16'h0F0F;
         step();
         if (out_valid !== 1'b1 || sum !== held || in_ready !== 1'b0) errs++;
      end
      in_valid = 1'b0;
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL backpressure_hold unstable_cycles=%0d required 0", errs);
      end
      total++;
      if (sb.size() != 1) begin
         bad++;
         $display("FAIL backpressure_ignored queued=%0d required 1", sb.size());
      end
      e = sb.pop_front();
      total++;
      if ({sum, carry_out, overflow} !== {e.s, e.c, e.v}) begin
         bad++;
         $display("FAIL backpressure_result got %h/%b/%b required %h/%b/%b",
                  sum, carry_out, overflow, e.s, e.c, e.v);
      end
      out_ready = 1'b1;
      step();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL backpressure_release rdy=%b vld=%b required 1 0", in_ready, out_valid);
      end
      accept(16'h0100, 16'h0200, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      total++;
      if (sum !== e.s || lat !== 5) begin
         bad++;
         $display("FAIL backpressure_next sum=%h lat=%0d required %h 5", sum, lat, e.s);
      end
      step();
   endtask

   task automatic test_reset_mid_run();
      int   lat;
      exp_t e;
      accept(16'h4321, 16'h1234, 1'b0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      sb.delete();
      total++;
      if ({in_ready, out_valid, sum, carry_out, overflow, add_cin} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
         bad++;
         $display("FAIL midrun_reset rdy=%b vld=%b sum=%h co=%b ov=%b required 1 0 0000 0 0",
                  in_ready, out_valid, sum, carry_out, overflow);
      end
      // reset and in_valid together: nothing may be accepted
      reset = 1'b1;
      in_valid = 1'b1;
      step();
      reset = 1'b0;
      in_valid = 1'b0;
      step();
      total++;
      if (in_ready !== 1'b1 || {add_a, add_b} !== 8'h0) begin
         bad++;
         $display("FAIL reset_wins rdy=%b a=%h b=%h required 1 0 0", in_ready, add_a, add_b);
      end
      accept(16'h0001, 16'h0001, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      total++;
      if (sum !== 16'h0002 || {sum, carry_out, overflow} !== {e.s, e.c, e.v}) begin
         bad++;
         $display("FAIL post_reset_add sum=%h required 0002", sum);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int           lat;
      exp_t         e;
      logic [W-1:0] a, b;
      logic         s;
      for (int k = 0; k < 8; k++) begin
         a = W'($urandom);
         b = W'($urandom);
         s = 1'($urandom);
         accept(a, b, s);
         wait_done(lat);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b2b_empty_queue k=%0d", k);
         end else begin
            e = sb.pop_front();
            total++;
            if ({sum, carry_out, overflow} !== {e.s, e.c, e.v} || lat !== 5) begin
               bad++;
               $display("FAIL b2b_%0d %h%s%h got %h/%b/%b lat=%0d required %h/%b/%b lat=5",
                        k, a, s ? "-" : "+", b, sum, carry_out, overflow, lat, e.s, e.c, e.v);
            end
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_carry_chain();
      test_overflow();
      test_sub();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
